// File: rtl/inv_decrypt_ctrl_if.sv
// Bundle of the decryption sequencer's handshake, result and external datapath signals.
// slave modport is the sequencer's view; master modport is the driver/stub view.
// Ports: start/cipher_in/key_in/in_ready (request), plain_out/out_valid/out_ready (result),
//        kg_count/kg_key/kg_keyout (key generation), ic_code/ic_last/ic_altered (inverse round), busy.
interface inv_decrypt_ctrl_if;
    logic        start;
    logic [15:0] cipher_in;
    logic [15:0] key_in;
    logic        in_ready;
    logic        busy;
    logic [15:0] plain_out;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  kg_count;
    logic [15:0] kg_key;
    logic [15:0] kg_keyout;
    logic [15:0] ic_code;
    logic        ic_last;
    logic [15:0] ic_altered;

    modport slave (
        input  start, cipher_in, key_in, out_ready, kg_keyout, ic_altered,
        output in_ready, busy, plain_out, out_valid, kg_count, kg_key, ic_code, ic_last
    );

    modport master (
        output start, cipher_in, key_in, out_ready, kg_keyout, ic_altered,
        input  in_ready, busy, plain_out, out_valid, kg_count, kg_key, ic_code, ic_last
    );
endinterface

// File: rtl/inv_decrypt_ctrl.sv
// Purpose: sequences one decryption: forward round-key expansion into a local buffer, then
//          ROUNDS inverse rounds consuming keys in reverse, then holds the plaintext.
// Latency: out_valid rises 2*ROUNDS+2 cycles after the accept edge; one request at a time.
// Backpressure: plain_out/out_valid held until out_ready; start ignored unless in_ready (IDLE).
// Ports: clk, rst (sync, active-high), bus (inv_decrypt_ctrl_if.slave).
module inv_decrypt_ctrl #(
    parameter int ROUNDS = 2
) (
    input  logic               clk,
    input  logic               rst,
    inv_decrypt_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_EXPAND = 3'd1;
    localparam logic [2:0] S_INIT   = 3'd2;
    localparam logic [2:0] S_ROUND  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [3:0] LAST_IDX = 4'(ROUNDS);

    logic [2:0]  fsm_q,   fsm_d;
    logic [15:0] state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [15:0] plain_q, plain_d;
    logic        valid_q, valid_d;

    logic [15:0] key_q [0:ROUNDS];
    logic        key_we;
    logic [3:0]  key_widx;
    logic [15:0] key_wdat;

    logic [15:0] key_prev;   // key[cnt-1], fed to key generation during EXPAND
    logic [15:0] key_cur;    // key[cnt], added after each inverse round

    // Key buffer reads compare the full 4-bit counter so no index narrowing is needed.
    always_comb begin
        key_prev = '0;
        key_cur  = '0;
        for (int k = 0; k <= ROUNDS; k++) begin
            if (cnt_q == 4'(k + 1)) key_prev = key_q[k];
            if (cnt_q == 4'(k))     key_cur  = key_q[k];
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        plain_d  = plain_q;
        valid_d  = valid_q;
        key_we   = 1'b0;
        key_widx = cnt_q;
        key_wdat = bus.kg_keyout;
        case (fsm_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = bus.cipher_in;
                    cnt_d    = 4'd1;
                    key_we   = 1'b1;
                    key_widx = 4'd0;
                    key_wdat = bus.key_in;
                    fsm_d    = S_EXPAND;
                end
            end
            S_EXPAND: begin
                key_we = 1'b1;
                if (cnt_q == LAST_IDX) fsm_d = S_INIT;
                else                   cnt_d = cnt_q + 4'd1;
            end
            S_INIT: begin
                state_d = state_q ^ key_q[ROUNDS];
                cnt_d   = LAST_IDX - 4'd1;
                fsm_d   = S_ROUND;
            end
            S_ROUND: begin
                state_d = bus.ic_altered ^ key_cur;
                if (cnt_q == 4'd0) fsm_d = S_DONE;
                else               cnt_d = cnt_q - 4'd1;
            end
            S_DONE: begin
                // First DONE cycle loads the output register; afterwards wait for the consumer.
                if (!valid_q) begin
                    valid_d = 1'b1;
                    plain_d = state_q;
                end else if (bus.out_ready) begin
                    valid_d = 1'b0;
                    plain_d = '0;
                    fsm_d   = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            cnt_q   <= '0;
            plain_q <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            plain_q <= plain_d;
            valid_q <= valid_d;
        end
    end

    // Key buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k <= ROUNDS; k++) begin
            if (key_we && key_widx == 4'(k)) key_q[k] <= key_wdat;
        end
    end

    assign bus.in_ready  = (fsm_q == S_IDLE);
    assign bus.busy      = (fsm_q != S_IDLE);
    assign bus.plain_out = plain_q;
    assign bus.out_valid = valid_q;
    assign bus.kg_count  = (fsm_q == S_EXPAND) ? cnt_q : 4'd0;
    assign bus.kg_key    = (fsm_q == S_EXPAND) ? key_prev : 16'd0;
    assign bus.ic_code   = state_q;
    assign bus.ic_last   = (fsm_q == S_ROUND) && (cnt_q == 4'd0);

endmodule

// File: tb/tb_inv_decrypt_ctrl.sv
module tb_inv_decrypt_ctrl;

    localparam int R = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inv_decrypt_ctrl_if bus ();
    inv_decrypt_ctrl_if bus1 ();

    // Stub datapath
    assign bus.kg_keyout  = bus.kg_key + {12'd0, bus.kg_count};
    assign bus.ic_altered = ~bus.ic_code;
    assign bus1.kg_keyout  = bus1.kg_key + {12'd0, bus1.kg_count};
    assign bus1.ic_altered = ~bus1.ic_code;

    inv_decrypt_ctrl #(.ROUNDS(R)) dut  (.clk(clk), .rst(rst), .bus(bus));
    inv_decrypt_ctrl #(.ROUNDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: forward key schedule with key[i]=key[i-1]+i, then whitening with the last key
    // and inverse rounds s = ~s ^ key[r] for r = rounds-1 .. 0.
    function automatic logic [15:0] ref_plain(input logic [15:0] c, input logic [15:0] k0,
                                              input int rounds);
        logic [15:0] ks [0:15];
        logic [15:0] s;
        ks[0] = k0;
        for (int i = 1; i <= rounds; i++) ks[i] = ks[i-1] + 16'(i);
        s = c ^ ks[rounds];
        for (int r = rounds - 1; r >= 0; r--) s = ~s ^ ks[r];
        return s;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [15:0] exp_q [$];
    bit          active = 0, rst_pend = 0, acc_pend = 0, done_pend = 0, seen_valid = 0;
    int          acc_cyc = 0;
    int          hs_cnt = 0;
    logic [15:0] last_hs = '0;
    logic [15:0] m_keys [0:R];
    logic [15:0] m_rs   [0:R-1];
    logic [15:0] m_cipher, m_plain;

    always @(negedge clk) begin
        int d;
        int r;
        logic [15:0] s;
        if (rst_pend) begin
            active = 0; acc_pend = 0; done_pend = 0;
            exp_q.delete();
            chk("rst_in_ready",  bus.in_ready, 1);
            chk("rst_busy",      bus.busy, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_plain_out", bus.plain_out, 0);
            chk("rst_kg_count",  bus.kg_count, 0);
            chk("rst_kg_key",    bus.kg_key, 0);
            chk("rst_ic_code",   bus.ic_code, 0);
            chk("rst_ic_last",   bus.ic_last, 0);
        end else begin
            if (done_pend) begin active = 0; done_pend = 0; end
            if (acc_pend)  begin active = 1; acc_pend = 0; acc_cyc = cyc; seen_valid = 0; end
            if (!active) begin
                chk("idle_in_ready",  bus.in_ready, 1);
                chk("idle_busy",      bus.busy, 0);
                chk("idle_out_valid", bus.out_valid, 0);
                chk("idle_plain_out", bus.plain_out, 0);
                chk("idle_kg_count",  bus.kg_count, 0);
                chk("idle_kg_key",    bus.kg_key, 0);
                chk("idle_ic_last",   bus.ic_last, 0);
            end else begin
                d = cyc - acc_cyc;
                chk("act_busy",     bus.busy, 1);
                chk("act_in_ready", bus.in_ready, 0);
                if (d < R) begin
                    chk("exp_kg_count", bus.kg_count, d + 1);
                    chk("exp_kg_key",   bus.kg_key, m_keys[d]);
                    chk("exp_ic_code",  bus.ic_code, m_cipher);
                    chk("exp_ic_last",  bus.ic_last, 0);
                    chk("exp_out_valid", bus.out_valid, 0);
                end else if (d == R) begin
                    chk("init_kg_count", bus.kg_count, 0);
                    chk("init_kg_key",   bus.kg_key, 0);
                    chk("init_ic_code",  bus.ic_code, m_cipher);
                    chk("init_ic_last",  bus.ic_last, 0);
                    chk("init_out_valid", bus.out_valid, 0);
                end else if (d <= 2 * R) begin
                    r = 2 * R - d;
                    chk("rnd_kg_count", bus.kg_count, 0);
                    chk("rnd_kg_key",   bus.kg_key, 0);
                    chk("rnd_ic_code",  bus.ic_code, m_rs[r]);
                    chk("rnd_ic_last",  bus.ic_last, (r == 0));
                    chk("rnd_out_valid", bus.out_valid, 0);
                end else begin
                    chk("done_kg_count", bus.kg_count, 0);
                    chk("done_ic_last",  bus.ic_last, 0);
                    chk("done_ic_code",  bus.ic_code, m_plain);
                    if (d > 2 * R + 1) begin
                        chk("done_out_valid", bus.out_valid, 1);
                        chk("done_plain_hold", bus.plain_out, m_plain);
                    end
                end
                if (bus.out_valid && !seen_valid) begin
                    seen_valid = 1;
                    chk("latency", d, 2 * R + 2);
                end
                if (bus.out_valid && bus.out_ready) begin
                    hs_cnt++;
                    last_hs = bus.plain_out;
                    done_pend = 1;
                    if (exp_q.size() == 0) chk("sb_unexpected_output", 1, 0);
                    else chk("sb_plain", bus.plain_out, exp_q.pop_front());
                end
            end
        end
        rst_pend = rst;
        if (!rst && bus.start && bus.in_ready) begin
            acc_pend = 1;
            m_cipher = bus.cipher_in;
            m_keys[0] = bus.key_in;
            for (int i = 1; i <= R; i++) m_keys[i] = m_keys[i-1] + 16'(i);
            s = m_cipher ^ m_keys[R];
            for (int j = R - 1; j >= 0; j--) begin
                m_rs[j] = s;
                s = ~s ^ m_keys[j];
            end
            m_plain = s;
            exp_q.push_back(ref_plain(bus.cipher_in, bus.key_in, R));
        end
    end

    // ---------------- driver ----------------
    task automatic do_start(input logic [15:0] c, input logic [15:0] k);
        bit ok = 0;
        bus.cipher_in = c; bus.key_in = k; bus.start = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.in_ready && !rst) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("accept_timeout", ok, 1);
    endtask

    task automatic wait_done(input bit rand_bp);
        bit ok = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin ok = 1; break; end
            @(posedge clk); #1;
            bus.out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        chk("handshake_timeout", ok, 1);
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin ok = 1; break; end
        end
        chk("valid_timeout", ok, 1);
    endtask

    initial begin
        int h0;
        int a1;
        bit ok1;
        logic [15:0] c, k;
        bus.start = 0; bus.cipher_in = '0; bus.key_in = '0; bus.out_ready = 1;
        bus1.start = 0; bus1.cipher_in = '0; bus1.key_in = '0; bus1.out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;

        // Basic vector
        do_start(16'hABCD, 16'h1234);
        wait_done(0);
        chk("basic_plain", last_hs, 16'hB9FB);

        // Backpressure: hold for 10 cycles with out_valid high
        bus.out_ready = 0;
        do_start(16'hABCD, 16'h1234);
        wait_valid();
        repeat (9) @(negedge clk);
        @(posedge clk); #1;
        bus.out_ready = 1;
        wait_done(0);
        chk("bp_plain", last_hs, 16'hB9FB);

        // Start while busy (during EXPAND and during DONE)
        h0 = hs_cnt;
        bus.out_ready = 0;
        do_start(16'hABCD, 16'h1234);
        bus.cipher_in = 16'hFFFF; bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        wait_valid();
        @(posedge clk); #1;
        bus.cipher_in = 16'hFFFF; bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0; bus.out_ready = 1;
        wait_done(0);
        repeat (20) @(posedge clk); #1;
        chk("busy_start_plain", last_hs, 16'hB9FB);
        chk("busy_start_one_hs", hs_cnt - h0, 1);

        // Reset in the first ROUND cycle
        h0 = hs_cnt;
        do_start(16'hABCD, 16'h1234);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        repeat (10) @(posedge clk); #1;
        chk("reset_no_output", hs_cnt - h0, 0);
        do_start(16'h0000, 16'h0000);
        wait_done(0);
        chk("post_reset_plain", last_hs, 16'h0002);

        // Randomized runs with random backpressure
        for (int t = 0; t < 10; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            c = 16'($urandom); k = 16'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            do_start(c, k);
            wait_done(1);
            chk("rand_plain", last_hs, ref_plain(c, k, R));
        end

        // ROUNDS=1 build
        c = 16'($urandom); k = 16'($urandom);
        bus1.cipher_in = c; bus1.key_in = k; bus1.start = 1;
        ok1 = 0;
        a1 = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus1.in_ready) begin ok1 = 1; a1 = cyc + 1; break; end
        end
        chk("r1_accept_timeout", ok1, 1);
        @(posedge clk); #1;
        bus1.start = 0;
        ok1 = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus1.out_valid) begin ok1 = 1; break; end
        end
        chk("r1_valid_timeout", ok1, 1);
        chk("r1_latency", cyc - a1, 4);
        chk("r1_plain", bus1.plain_out, ref_plain(c, k, 1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("r1_idle_in_ready", bus1.in_ready, 1);
        chk("r1_idle_out_valid", bus1.out_valid, 0);

        repeat (5) @(posedge clk);
        chk("sb_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_decrypt_ctrl.md
Name: inv_decrypt_ctrl

Overview:
Sequencer for the 16-bit decryption datapath. It accepts one ciphertext/key pair and expands the round keys forward through the external key-generation unit into a local key buffer. It then runs the inverse-round computation unit once per round, consuming the keys in reverse order, and holds the plaintext until the consumer accepts it. It owns the state register, the round counter and the key buffer; the key-generation and inverse-computation units stay combinational and external.

Parameters:
ROUNDS, 2, number of inverse rounds (legal 1..15); key buffer holds ROUNDS+1 entries.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request to begin; accepted only when start && in_ready
cipher_in  in  16  ciphertext, sampled on accept
key_in  in  16  cipher key (round key 0), sampled on accept
in_ready  out  1  high only in IDLE
busy  out  1  high in EXPAND, INIT, ROUND, DONE
plain_out  out  16  plaintext, valid while out_valid
out_valid  out  1  high in DONE
out_ready  in  1  consumer accept
kg_count  out  4  round index to key-generation unit; 0 outside EXPAND
kg_key  out  16  previous round key to key-generation unit; 0 outside EXPAND
kg_keyout  in  16  next round key from key-generation unit
ic_code  out  16  current state word to inverse-computation unit (= state register)
ic_last  out  1  high during the final ROUND cycle; datapath omits inverse MixColumns
ic_altered  in  16  inverse-computation result, without key addition

Behaviour:
- Reset (rst=1 at an edge): FSM to IDLE; state, counter and all outputs to 0, except in_ready=1. Key buffer contents are don't-care. Reset aborts any operation in flight, with no output produced.
- IDLE: in_ready=1. On start, at the edge:
  - state<=cipher_in, key[0]<=key_in, i<=1, go to EXPAND.
  - start while not IDLE is ignored, with no queueing.
- EXPAND (ROUNDS cycles, i=1..ROUNDS):
  - kg_count=i, kg_key=key[i-1].
  - At the edge: key[i]<=kg_keyout.
  - After i==ROUNDS, go to INIT.
- INIT (1 cycle): state<=state^key[ROUNDS]; r<=ROUNDS-1; go to ROUND.
- ROUND (ROUNDS cycles, r=ROUNDS-1 down to 0):
  - ic_code=state; ic_last=(r==0).
  - At the edge: state<=ic_altered^key[r].
  - After r==0, go to DONE.
- DONE:
  - out_valid=1, plain_out=state, both held stable until out_ready.
  - out_valid && out_ready: go to IDLE, out_valid<=0, plain_out<=0.
- Latency: out_valid rises 2*ROUNDS+2 cycles after the accept edge (6 for ROUNDS=2).
- Throughput: no back-to-back accepts. There is at least one IDLE cycle between the DONE handshake and the next accept.
- kg_count/kg_key are 0 outside EXPAND; ic_last is 0 outside ROUND.
- All arithmetic is XOR on 16 bits. Counters are 4 bits wide and never wrap, because ROUNDS≤15.

Test Plan:
- Bench stub datapath: kg_keyout=kg_key+kg_count (mod 2^16), ic_altered=~ic_code.
- Basic (ROUNDS=2): key_in=0x1234, cipher_in=0xABCD, start for 1 cycle, out_ready=1 -> keys 0x1234/0x1235/0x1237; state after INIT 0xB9FA, after r=1 0x5430; plain_out=0xB9FB with out_valid at cycle 6 after accept; ic_last high exactly in the second ROUND cycle.
- Backpressure: same vector, out_ready=0 for 10 cycles then 1 -> out_valid and plain_out=0xB9FB held stable all 10 cycles; IDLE/in_ready=1 the cycle after the handshake.
- Start while busy: pulse start with cipher_in=0xFFFF during EXPAND and again during DONE -> ignored; result still 0xB9FB; exactly one out_valid handshake.
- Reset mid-operation: assert rst in the first ROUND cycle -> next cycle all outputs 0, in_ready=1; a new run with key 0x0000 and cipher 0x0000 gives keys 0/1/3, INIT 0x0003, r=1 0xFFFD, r=0 0x0002 -> plain_out=0x0002.
- Interface idle values: across a full run, check kg_count sequence 0,1,2,0 and kg_key=0 outside EXPAND; ic_code equals the state register; busy matches the FSM state; ROUNDS=1 build gives latency 4.
